// File: rtl/window_convolution.sv
// window_convolution: streaming window x kernel multiply-accumulate with round, shift and clamp
module window_convolution #(
  parameter int WINDOW_HEIGHT = 3,
  parameter int WINDOW_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int COEFF_WIDTH = 8,
  parameter int SHIFT = 4
) (
  input  logic                                              clock_i,
  input  logic                                              reset_i,
  input  logic                                              slave_valid_i,
  output logic                                              slave_ready_o,
  input  logic [WINDOW_HEIGHT*WINDOW_WIDTH*DATA_WIDTH-1:0]  slave_data_i,
  input  logic                                              coeff_write_i,
  input  logic [$clog2(WINDOW_HEIGHT*WINDOW_WIDTH)-1:0]     coeff_index_i,
  input  logic [COEFF_WIDTH-1:0]                            coeff_data_i,
  output logic                                              master_valid_o,
  input  logic                                              master_ready_i,
  output logic [DATA_WIDTH-1:0]                             master_data_o
);
  localparam int N = WINDOW_HEIGHT * WINDOW_WIDTH;
  localparam int IW = $clog2(N);
  localparam int PW = DATA_WIDTH + COEFF_WIDTH + 1;
  localparam int SW = PW + $clog2(N);
  localparam int RW = SW + 1;
  localparam int CENTRE = (WINDOW_HEIGHT / 2) * WINDOW_WIDTH + WINDOW_WIDTH / 2;
  localparam logic signed [RW-1:0] RND = RW'((2 ** SHIFT) / 2);
  localparam logic signed [RW-1:0] MAXV = RW'(2 ** DATA_WIDTH - 1);

  logic signed [COEFF_WIDTH-1:0] coeff [N];
  logic signed [PW-1:0]          prod [N];
  logic [DATA_WIDTH-1:0]         pix_c [N];
  logic signed [SW-1:0]          sum_c, sum_q;
  logic signed [RW-1:0]          rnd_c, shf_c;
  logic [DATA_WIDTH-1:0]         clamp_c;
  logic                          v1, v2, adv;

  // whole pipeline moves together whenever the output slot is free or being drained
  assign adv = !master_valid_o || master_ready_i;
  assign slave_ready_o = reset_i && adv;

  // element k of the window; element 0 (top-left) sits in the MSBs
  for (genvar i = 0; i < N; i++) begin : g_pix
    assign pix_c[i] = slave_data_i[(N-1-i)*DATA_WIDTH +: DATA_WIDTH];
  end

  // kernel storage: reset to a centre pass-through, out-of-range indices match no entry
  always_ff @(posedge clock_i or negedge reset_i)
    if (!reset_i) begin
      for (int k = 0; k < N; k++) coeff[k] <= (k == CENTRE) ? COEFF_WIDTH'(2 ** SHIFT) : '0;
    end else if (coeff_write_i) begin
      for (int k = 0; k < N; k++) if (coeff_index_i == IW'(k)) coeff[k] <= coeff_data_i;
    end

  // full-precision sum of the registered products, wide enough that it cannot overflow
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < N; k++) sum_c = sum_c + SW'(prod[k]);
  end

  // round half up, arithmetic shift, then saturate to the unsigned pixel range
  always_comb begin
    rnd_c = RW'(sum_q) + RND;
    shf_c = rnd_c >>> SHIFT;
    clamp_c = (shf_c < 0) ? '0 : (shf_c > MAXV) ? MAXV[DATA_WIDTH-1:0] : shf_c[DATA_WIDTH-1:0];
  end

  // three-stage pipeline: products, sum, clamped result; bubbles travel with their valid bits
  always_ff @(posedge clock_i or negedge reset_i)
    if (!reset_i) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      master_valid_o <= 1'b0;
      master_data_o <= '0;
      sum_q <= '0;
      for (int k = 0; k < N; k++) prod[k] <= '0;
    end else if (adv) begin
      v1 <= slave_valid_i;
      v2 <= v1;
      master_valid_o <= v2;
      sum_q <= sum_c;
      master_data_o <= clamp_c;
      for (int k = 0; k < N; k++) prod[k] <= PW'($signed({1'b0, pix_c[k]})) * PW'(coeff[k]);
    end
endmodule

// File: tb/tb_window_convolution.sv
// tb_window_convolution: directed tests with a reference kernel model checked every cycle
module tb_window_convolution;
  localparam int SHIFT = 4;
  localparam int N = 9;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        slave_valid_i = 1'b0;
  logic        slave_ready_o;
  logic [71:0] slave_data_i = '0;
  logic        coeff_write_i = 1'b0;
  logic [3:0]  coeff_index_i = '0;
  logic [7:0]  coeff_data_i = '0;
  logic        master_valid_o;
  logic        master_ready_i = 1'b1;
  logic [7:0]  master_data_o;

  int checks = 0;
  int errors = 0;
  int mk [N];
  int q [$];
  int last_out = -1;
  int n_out = 0;
  bit rand_rdy = 0;
  bit stall_prev = 0;
  logic [7:0] prev_data = '0;

  window_convolution #(.WINDOW_HEIGHT(3), .WINDOW_WIDTH(3), .DATA_WIDTH(8), .COEFF_WIDTH(8), .SHIFT(SHIFT)) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .slave_valid_i(slave_valid_i), .slave_ready_o(slave_ready_o), .slave_data_i(slave_data_i),
    .coeff_write_i(coeff_write_i), .coeff_index_i(coeff_index_i), .coeff_data_i(coeff_data_i),
    .master_valid_o(master_valid_o), .master_ready_i(master_ready_i), .master_data_o(master_data_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // reference: plain integer dot product, round, floor-shift, saturate
  function automatic int model(input logic [71:0] w);
    int s = 0;
    for (int k = 0; k < N; k++) s += int'(w[(8-k)*8 +: 8]) * mk[k];
    s = (s + (1 << SHIFT) / 2) >>> SHIFT;
    return s < 0 ? 0 : s > 255 ? 255 : s;
  endfunction

  function automatic logic [71:0] seq();
    logic [71:0] w;
    for (int k = 0; k < N; k++) w[(8-k)*8 +: 8] = 8'(k + 1);
    return w;
  endfunction

  function automatic logic [71:0] win_c(input int c, input int o);
    logic [71:0] w;
    for (int k = 0; k < N; k++) w[(8-k)*8 +: 8] = (k == 4) ? 8'(c) : 8'(o);
    return w;
  endfunction

  // scoreboard, kernel model and protocol checks, sampled mid-cycle
  always @(negedge clock_i) begin
    if (!reset_i) begin
      q.delete();
      for (int k = 0; k < N; k++) mk[k] = (k == 4) ? (1 << SHIFT) : 0;
      stall_prev = 0;
      chk("rst_valid", master_valid_o, 0);
      chk("rst_ready", slave_ready_o, 0);
      chk("rst_data", master_data_o, 0);
    end else begin
      chk("ready_rule", slave_ready_o, !master_valid_o || master_ready_i);
      if (stall_prev) begin
        chk("stall_valid", master_valid_o, 1);
        chk("stall_data", master_data_o, prev_data);
      end
      if (master_valid_o) begin
        if (q.size() == 0) chk("spurious_out", master_data_o, 32'hFFFF_FFFF);
        else begin
          chk("out_data", master_data_o, q[0]);
          if (master_ready_i) begin
            last_out = q[0];
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      stall_prev = master_valid_o && !master_ready_i;
      prev_data = master_data_o;
      if (slave_valid_i && slave_ready_o) q.push_back(model(slave_data_i));
      if (coeff_write_i && coeff_index_i < 9) mk[coeff_index_i] = $signed(coeff_data_i);
    end
  end

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic send(input logic [71:0] w);
    bit ok = 0;
    slave_valid_i = 1'b1;
    slave_data_i = w;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (rand_rdy) master_ready_i = 1'($urandom_range(0, 1));
      #1;
      ok = slave_ready_o;
      tick();
    end
    slave_valid_i = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic wr(input int idx, input int val);
    coeff_write_i = 1'b1;
    coeff_index_i = 4'(idx);
    coeff_data_i = 8'(val);
    tick();
    coeff_write_i = 1'b0;
  endtask

  task automatic kernel_all(input int val);
    for (int k = 0; k < N; k++) wr(k, val);
  endtask

  task automatic kernel_centre(input int val);
    for (int k = 0; k < N; k++) wr(k, k == 4 ? val : 0);
  endtask

  task automatic expect_out(input string name, input int exp);
    for (int i = 0; i < 20 && !master_valid_o; i++) tick();
    chk({name, "_valid"}, master_valid_o, 1);
    chk(name, master_data_o, exp);
    tick();
  endtask

  initial begin
    int n0;
    repeat (3) tick();
    chk("reset_valid", master_valid_o, 0);
    chk("reset_data", master_data_o, 0);
    reset_i = 1'b1;
    tick();
    chk("pin_seq", model(seq()), 5);
    // 1: reset kernel, latency and back-to-back throughput
    send(seq());
    chk("lat_s1", master_valid_o, 0);
    tick();
    chk("lat_s2", master_valid_o, 0);
    tick();
    chk("lat_s3_valid", master_valid_o, 1);
    chk("lat_s3_data", master_data_o, 5);
    tick();
    for (int i = 11; i <= 14; i++) send(win_c(i, 0));
    chk("b2b_12", master_data_o, 12);
    tick();
    chk("b2b_13", master_data_o, 13);
    tick();
    chk("b2b_14", master_data_o, 14);
    tick();
    chk("b2b_done", master_valid_o, 0);
    // 2: clamp high and clamp low
    kernel_all(16);
    chk("pin_hi", model({9{8'd200}}), 255);
    send({9{8'd200}});
    expect_out("clamp_hi", 255);
    kernel_centre(-16);
    chk("pin_lo", model(win_c(50, 200)), 0);
    send(win_c(50, 200));
    expect_out("clamp_lo", 0);
    // 3: box blur with rounding
    kernel_all(1);
    chk("pin_blur", model({9{8'd10}}), 6);
    send({9{8'd10}});
    expect_out("blur", 6);
    send(seq());
    expect_out("blur_seq", 3);
    // 4: backpressure stream under the pass-through kernel
    kernel_centre(16);
    n0 = n_out;
    rand_rdy = 1;
    for (int i = 1; i <= 20; i++) send(win_c(i, int'($urandom_range(0, 255))));
    for (int i = 0; i < 200 && q.size() > 0; i++) begin
      master_ready_i = 1'($urandom_range(0, 1));
      tick();
    end
    rand_rdy = 0;
    master_ready_i = 1'b1;
    tick();
    chk("bp_drained", q.size(), 0);
    chk("bp_last", last_out, 20);
    chk("bp_count", n_out - n0, 20);
    // 5: coefficient write on the same edge as window A
    slave_valid_i = 1'b1;
    slave_data_i = win_c(33, 9);
    coeff_write_i = 1'b1;
    coeff_index_i = 4'd4;
    coeff_data_i = 8'd0;
    tick();
    coeff_write_i = 1'b0;
    slave_data_i = win_c(44, 9);
    tick();
    slave_valid_i = 1'b0;
    tick();
    chk("cw_a_valid", master_valid_o, 1);
    chk("cw_a", master_data_o, 33);
    tick();
    chk("cw_b_valid", master_valid_o, 1);
    chk("cw_b", master_data_o, 0);
    tick();
    wr(4, 16);
    wr(9, 100);
    send(win_c(77, 50));
    expect_out("idx_oob", 77);
    // 6: reset with windows in flight reloads the kernel and discards results
    kernel_centre(32);
    send(win_c(10, 1));
    send(win_c(20, 1));
    send(win_c(30, 1));
    reset_i = 1'b0;
    #1;
    chk("mid_rst_valid", master_valid_o, 0);
    chk("mid_rst_ready", slave_ready_o, 0);
    chk("mid_rst_data", master_data_o, 0);
    repeat (2) tick();
    reset_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_idle", master_valid_o, 0);
    end
    send(win_c(99, 5));
    expect_out("post_rst", 99);
    repeat (3) tick();
    chk("final_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
